// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I instruction-fetch stage with single-outstanding imem port and IF/ID register

package fetch_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] instr;
    } if_id_t;
endpackage

module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output logic              imem_req,
    output logic [31:0]       imem_addr,
    input  logic              imem_ready,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output fetch_pkg::if_id_t if_id,
    output logic              if_id_valid
);

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_WAIT,
        ST_HOLD,
        ST_DRAIN
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       hold_instr_q, hold_instr_d;
    logic [31:0]       hold_pc_q, hold_pc_d;
    logic              hold_valid_q, hold_valid_d;
    fetch_pkg::if_id_t if_id_q, if_id_d;
    logic              if_id_valid_q, if_id_valid_d;

    logic [31:0]       pc_plus4;
    logic [31:0]       hold_pc_plus4;
    logic              accept;
    fetch_pkg::if_id_t bubble;
    logic              unused_redirect_lsbs;

    assign pc_plus4             = pc_q + 32'd4;
    assign hold_pc_plus4        = hold_pc_q + 32'd4;
    assign bubble               = {32'd0, 32'd0, NOP_INSTR};
    assign accept               = imem_req && imem_ready;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // In WAIT the next request is issued in the same cycle the response lands,
    // which is what gives back-to-back fetch with a one-cycle memory.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc_q;
        if (!reset && !redirect) begin
            case (state_q)
                ST_FETCH: imem_req = 1'b1;
                ST_WAIT: begin
                    if (imem_rvalid && !stall) begin
                        imem_req  = 1'b1;
                        imem_addr = pc_plus4;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        hold_instr_d  = hold_instr_q;
        hold_pc_d     = hold_pc_q;
        hold_valid_d  = hold_valid_q;
        if_id_d       = if_id_q;
        if_id_valid_d = if_id_valid_q;

        if (redirect) begin
            pc_d          = {redirect_pc[31:2], 2'b00};
            if_id_d       = bubble;
            if_id_valid_d = 1'b0;
            hold_valid_d  = 1'b0;
            if ((state_q == ST_WAIT || state_q == ST_DRAIN) && !imem_rvalid) begin
                state_d = ST_DRAIN;
            end else begin
                state_d = ST_FETCH;
            end
        end else begin
            // Decode consumed the current entry; replace it with a bubble
            // unless a new instruction is written below.
            if (!stall) begin
                if_id_d       = bubble;
                if_id_valid_d = 1'b0;
            end
            case (state_q)
                ST_FETCH: begin
                    if (accept) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid && !stall) begin
                        if_id_d       = {pc_q, pc_plus4, imem_rdata};
                        if_id_valid_d = 1'b1;
                        pc_d          = pc_plus4;
                        state_d       = accept ? ST_WAIT : ST_FETCH;
                    end else if (imem_rvalid) begin
                        hold_instr_d = imem_rdata;
                        hold_pc_d    = pc_q;
                        hold_valid_d = 1'b1;
                        pc_d         = pc_plus4;
                        state_d      = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        if_id_d       = {hold_pc_q, hold_pc_plus4, hold_instr_q};
                        if_id_valid_d = hold_valid_q;
                        hold_valid_d  = 1'b0;
                        state_d       = ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    if (imem_rvalid) begin
                        state_d = ST_FETCH;
                    end
                end
                default: state_d = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_FETCH;
            pc_q          <= RESET_PC;
            hold_instr_q  <= NOP_INSTR;
            hold_pc_q     <= 32'd0;
            hold_valid_q  <= 1'b0;
            if_id_q       <= {32'd0, 32'd0, NOP_INSTR};
            if_id_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            hold_instr_q  <= hold_instr_d;
            hold_pc_q     <= hold_pc_d;
            hold_valid_q  <= hold_valid_d;
            if_id_q       <= if_id_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

    assign if_id       = if_id_q;
    assign if_id_valid = if_id_valid_q;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage RV32I pipeline. Owns the PC and drives a single-outstanding request/response instruction-memory port. It loads the IF/ID pipeline register (`fetch_pkg::if_id_t`) consumed by decode. It handles decode back-pressure (load-use stall) and branch redirects, including squashing an in-flight fetch.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC after reset.
- `NOP_INSTR`, default 32'h0000_0013: bubble encoding (`addi x0,x0,0`).

- `clk`  in  1: clock.
- `reset`  in  1: reset, asynchronous, active-high.
- `stall`  in  1: decode cannot accept; hold IF/ID and PC. Driven from `load_use_stall`.
- `redirect`  in  1: branch/jump taken (`take_branch`). Flush and retarget.
- `redirect_pc`  in  32: new PC; bits [1:0] ignored (forced 0).
- `imem_req`  out  1: fetch request valid.
- `imem_addr`  out  32: word-aligned fetch address.
- `imem_ready`  in  1: memory accepts request this cycle (`imem_req && imem_ready` = accept).
- `imem_rvalid`  in  1: response valid; not back-pressurable. At most one response per accepted request, at least 1 cycle after accept.
- `imem_rdata`  in  32: instruction word.
- `if_id`  out  `fetch_pkg::if_id_t`: {pc, pc_plus4, instr}, registered.
- `if_id_valid`  out  1: `if_id` holds a real instruction.

## Operation
- Registers: `pc_q`, state, a 1-entry hold buffer (`hold_instr`, `hold_pc`), and `if_id`/`if_id_valid`.
- States:
  - FETCH: `imem_req=1`, `imem_addr=pc_q`. Accept → WAIT.
  - WAIT: awaiting response.
    - `rvalid && !stall`: write IF/ID {pc_q, pc_q+4, rdata}, valid=1, `pc_q<=pc_q+4`. In the same cycle, `imem_req=1` with `imem_addr=pc_q+4`. If accepted, stay WAIT; else → FETCH.
    - `rvalid && stall`: capture into hold buffer, `pc_q<=pc_q+4`, → HOLD.
  - HOLD: no request. When `!stall`: write IF/ID from hold buffer, valid=1, → FETCH.
  - DRAIN: a squashed response is outstanding, no request. On `rvalid`: discard data, → FETCH.
- Redirect has highest priority over stall and all state actions, every state:
  - `pc_q <= {redirect_pc[31:2],2'b00}`.
  - IF/ID ← {0, 0, NOP_INSTR}, valid=0.
  - Hold buffer invalidated.
  - `imem_req` forced 0 that cycle.
  - Next state:
    - WAIT without `rvalid` → DRAIN.
    - WAIT with `rvalid` → FETCH (response discarded).
    - DRAIN without `rvalid` → stays DRAIN.
    - Otherwise → FETCH.
- Stall without redirect: IF/ID unchanged, no IF/ID write.
- Decode consumes (`!stall`) with no new instruction available: IF/ID ← bubble {0, 0, NOP_INSTR}, valid=0. An instruction is never presented twice.
- `pc_plus4 = pc + 4`, 32-bit, wraps modulo 2^32 (0xFFFF_FFFC → 0x0000_0000).
- `imem_rvalid` in FETCH or HOLD is a protocol violation and is ignored.

## Timing
- Reset values:
  - `pc_q=RESET_PC`, state FETCH.
  - `if_id={0,0,NOP_INSTR}`, `if_id_valid=0`, hold buffer invalid.
  - `imem_req=0` while reset is asserted; 1 in the first cycle after release.
- Reset mid-operation: all state is cleared immediately. A response to a pre-reset request that arrives after release lands in FETCH and is ignored.
- Latency: for a request accepted in cycle N with `rvalid` in cycle N+k, IF/ID is visible in cycle N+k+1.
- Throughput: with `imem_ready=1` and k=1, one instruction per cycle (back-to-back via the WAIT self-loop).
- `imem_req` and `imem_addr` depend combinationally on `imem_rvalid`, `stall` and `redirect` in WAIT; all other outputs are registered.
- Simultaneous `redirect && stall`: redirect wins; IF/ID is flushed regardless of stall.

## Test plan
- Reset with `RESET_PC=0x100`, ideal memory (ready=1, rvalid 1 cycle later): `imem_addr` sequence 0x100, 0x104, 0x108; IF/ID shows pc 0x100/0x104/0x108 on consecutive cycles, `pc_plus4` = pc+4, valid=1.
- `stall` for 3 cycles while a response arrives (instr 0x00500093 at 0x104): IF/ID holds the previous instruction. After release, IF/ID = {0x104, 0x108, 0x00500093} exactly once, then 0x108 follows. No duplicate, no drop.
- `redirect` to 0x200 while in WAIT (response arrives 2 cycles later): IF/ID becomes NOP, valid=0; the late response is discarded; next `imem_addr=0x200`; first valid IF/ID pc=0x200.
- `redirect` and `rvalid` in the same cycle, with `redirect_pc=0x303`: response dropped, `imem_addr=0x300` next cycle, FETCH.
- Memory with `imem_ready` low 4 cycles: `imem_req` held high, `imem_addr` stable; no IF/ID write; IF/ID drains to a bubble if decode is not stalled.
- PC wrap: `redirect_pc=0xFFFF_FFFC` → IF/ID pc=0xFFFF_FFFC, pc_plus4=0x0000_0000, next fetch at 0x0. Assert reset mid-WAIT → all outputs return to reset values asynchronously.
